// File: rtl/pes_serializer_pkg.sv
// -----------------------------------------------------------------------------
// pes_serializer_pkg
// Shared types and sizing helpers for pes_bit_serializer.
//   serializer_state_e : 2-bit FSM state encoding (IDLE, ARMED, SHIFT, GAP)
//   PARITY_BITS        : 1 when PES_BIT_SERIALIZER_PARITY_EN is defined, else 0
//   pes_nbits()        : frame length in bits for a given data width
// Optional feature macro: PES_BIT_SERIALIZER_PARITY_EN (appends an even-parity
// bit to every frame).
// -----------------------------------------------------------------------------
package pes_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } serializer_state_e;

`ifdef PES_BIT_SERIALIZER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int pes_nbits(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/pes_bit_serializer.sv
// -----------------------------------------------------------------------------
// pes_bit_serializer
// Parallel-to-serial output stage. Accepts one WIDTH-bit word per valid/ready
// handshake and shifts it out on sout, one bit per bit_en strobe period, with
// frame (sframe) and first-bit (sfirst) markers.
//
// Parameters:
//   WIDTH      : data word width (>= 2)
//   MSB_FIRST  : 1 sends in_data[WIDTH-1] first, 0 sends in_data[0] first
//   GAP_BITS   : idle bit periods inserted after each frame (0 allowed)
//   IDLE_LEVEL : sout level whenever no frame bit is driven
// Ports:
//   clk      in   system clock
//   nrst     in   asynchronous active-low reset
//   bit_en   in   one-cycle bit-rate strobe
//   in_data  in   word to serialize, sampled on handshake
//   in_valid in   upstream word available
//   in_ready out  high only in IDLE
//   sout     out  registered serial data
//   sframe   out  registered, high while a frame bit is on sout
//   sfirst   out  registered, high while the first frame bit is on sout
//   busy     out  high in any state except IDLE
// Optional feature macro: PES_BIT_SERIALIZER_PARITY_EN appends an even-parity
// bit (XOR of the loaded word) as the last frame bit.
// -----------------------------------------------------------------------------
module pes_bit_serializer
  import pes_serializer_pkg::*;
#(
  parameter int   WIDTH      = 15,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP_BITS   = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             bit_en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sframe,
  output logic             sfirst,
  output logic             busy
);

  localparam int NBITS = pes_nbits(WIDTH);
  localparam int CW    = $clog2(NBITS + 1);
  localparam int GW    = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
`ifdef PES_BIT_SERIALIZER_PARITY_EN
  // When this many bits are done, the next bit out is the parity bit.
  localparam logic [CW-1:0] CNT_PAR  = CW'(WIDTH - 1);
`endif

  serializer_state_e state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              sout_q, sout_d;
  logic              sframe_q, sframe_d;
  logic              sfirst_q, sfirst_d;
`ifdef PES_BIT_SERIALIZER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // The next bit to send always sits at the head of the shift register;
  // the direction is fixed by MSB_FIRST at elaboration.
  logic             head_bit;
  logic [WIDTH-1:0] shift_next;

  assign head_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    sout_d   = sout_q;
    sframe_d = sframe_q;
    sfirst_d = sfirst_q;
`ifdef PES_BIT_SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
`ifdef PES_BIT_SERIALIZER_PARITY_EN
          parity_d = ^in_data;
`endif
          state_d = ARMED;
        end
      end
      // A strobe coincident with the handshake is not seen here, so the
      // first bit always spans a full bit period.
      ARMED: begin
        if (bit_en) begin
          sout_d   = head_bit;
          shift_d  = shift_next;
          sframe_d = 1'b1;
          sfirst_d = 1'b1;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (cnt_q < CNT_LAST) begin
            sout_d = head_bit;
`ifdef PES_BIT_SERIALIZER_PARITY_EN
            if (cnt_q == CNT_PAR) sout_d = parity_q;
`endif
            shift_d  = shift_next;
            cnt_d    = cnt_q + 1'b1;
            sfirst_d = 1'b0;
          end else begin
            sout_d   = IDLE_LEVEL;
            sframe_d = 1'b0;
            sfirst_d = 1'b0;
            cnt_d    = '0;
            gap_d    = '0;
            state_d  = (GAP_BITS > 0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (bit_en) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      sout_q   <= IDLE_LEVEL;
      sframe_q <= 1'b0;
      sfirst_q <= 1'b0;
`ifdef PES_BIT_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      sout_q   <= sout_d;
      sframe_q <= sframe_d;
      sfirst_q <= sfirst_d;
`ifdef PES_BIT_SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign sout     = sout_q;
  assign sframe   = sframe_q;
  assign sfirst   = sfirst_q;

endmodule

// File: tb/tb_pes_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_pes_bit_serializer
// Two serializer instances share clock, reset and bit_en:
//   u_dut0 : MSB first, one gap bit
//   u_dut1 : LSB first, no gap bits
// The reference model tracks each instance as a single count of bit_en strobes
// still owed after an accepted word (1 to start, NBITS bits, GAP_BITS idle),
// from which every output is derived each cycle.
// -----------------------------------------------------------------------------
module tb_pes_bit_serializer;

  localparam int W = 15;
`ifdef PES_BIT_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk;
  logic         nrst;
  logic         bit_en;
  logic [W-1:0] in_data0, in_data1;
  logic         in_valid0, in_valid1;
  logic [1:0]   in_ready, sout, sframe, sfirst, busy;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int           rem[2];
  int           acc_cnt[2];
  logic [W-1:0] cur[2];
  int           hi_cnt[2];
  int           last_len[2];

  int be_mode = 0;   // 0: every 4 clocks, 1: always high, 2: random

  pes_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_BITS(1), .IDLE_LEVEL(1'b1)) u_dut0 (
    .clk(clk), .nrst(nrst), .bit_en(bit_en), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready[0]), .sout(sout[0]), .sframe(sframe[0]), .sfirst(sfirst[0]), .busy(busy[0])
  );

  pes_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_BITS(0), .IDLE_LEVEL(1'b1)) u_dut1 (
    .clk(clk), .nrst(nrst), .bit_en(bit_en), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready[1]), .sout(sout[1]), .sframe(sframe[1]), .sfirst(sfirst[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gapv(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit msbv(input int i);
    return (i == 0);
  endfunction

  // Frame bit idx of word w: data bits in the chosen order, then parity.
  function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit msb);
    logic [W-1:0] t;
    t = w;
    if (idx >= W) return ^t;
    return msb ? t[W-1-idx] : t[idx];
  endfunction

  function automatic bit frame_on(input int i);
    return (rem[i] > gapv(i)) && (rem[i] <= NB + gapv(i));
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 2; i++) rem[i] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0) begin
          if ((i == 0) ? in_valid0 : in_valid1) begin
            cur[i]     <= (i == 0) ? in_data0 : in_data1;
            rem[i]     <= 1 + NB + gapv(i);
            acc_cnt[i] <= acc_cnt[i] + 1;
          end
        end else if (bit_en) begin
          rem[i] <= rem[i] - 1;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (nrst) begin
      for (int i = 0; i < 2; i++) begin
        check_val($sformatf("u%0d_sframe", i), {31'd0, sframe[i]}, {31'd0, frame_on(i)});
        check_val($sformatf("u%0d_sfirst", i), {31'd0, sfirst[i]}, {31'd0, rem[i] == NB + gapv(i)});
        check_val($sformatf("u%0d_sout", i), {31'd0, sout[i]},
                  {31'd0, frame_on(i) ? exp_bit(cur[i], NB + gapv(i) - rem[i], msbv(i)) : 1'b1});
        check_val($sformatf("u%0d_busy", i), {31'd0, busy[i]}, {31'd0, rem[i] != 0});
        check_val($sformatf("u%0d_in_ready", i), {31'd0, in_ready[i]}, {31'd0, rem[i] == 0});
        if (sframe[i]) hi_cnt[i] <= hi_cnt[i] + 1;
        else if (hi_cnt[i] != 0) begin
          last_len[i] <= hi_cnt[i];
          hi_cnt[i]   <= 0;
        end
      end
    end
  end

  // ---------------- bit_en source ----------------
  initial begin
    int ph;
    ph = 0;
    bit_en = 1'b0;
    forever begin
      @(negedge clk);
      ph++;
      case (be_mode)
        0:       bit_en = (ph % 4 == 0);
        1:       bit_en = 1'b1;
        default: bit_en = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // ---------------- word sources ----------------
  task automatic send(input int i, input logic [W-1:0] w, input bit keep);
    int start;
    bit done;
    start = acc_cnt[i];
    done  = 1'b0;
    if (i == 0) begin in_data0 = w; in_valid0 = 1'b1; end
    else        begin in_data1 = w; in_valid1 = 1'b1; end
    for (int k = 0; k < 5000 && !done; k++) begin
      @(negedge clk);
      if (acc_cnt[i] != start) done = 1'b1;
    end
    if (!done) check_val($sformatf("u%0d_accept_timeout", i), 32'd0, 32'd1);
    if (!keep) begin
      if (i == 0) in_valid0 = 1'b0;
      else        in_valid1 = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 5000 && !idle; k++) begin
      @(negedge clk);
      if (rem[0] == 0 && rem[1] == 0) idle = 1'b1;
    end
    if (!idle) check_val("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand_stream(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send(i, W'($urandom), ($urandom_range(0, 1) == 1));
    end
    if (i == 0) in_valid0 = 1'b0;
    else        in_valid1 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit hit;
    nrst = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    in_data0 = '0;    in_data1 = '0;
    for (int i = 0; i < 2; i++) begin
      acc_cnt[i] = 0; hi_cnt[i] = 0; last_len[i] = 0; cur[i] = '0;
    end

    // reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("rst_u%0d_sout", i), {31'd0, sout[i]}, 32'd1);
      check_val($sformatf("rst_u%0d_sframe", i), {31'd0, sframe[i]}, 32'd0);
      check_val($sformatf("rst_u%0d_sfirst", i), {31'd0, sfirst[i]}, 32'd0);
      check_val($sformatf("rst_u%0d_busy", i), {31'd0, busy[i]}, 32'd0);
      check_val($sformatf("rst_u%0d_in_ready", i), {31'd0, in_ready[i]}, 32'd1);
    end
    #2 nrst = 1'b1;

    // single directed frames, bit_en every 4 clocks
    be_mode = 0;
    fork
      send(0, 15'h2A5C, 1'b0);
      send(1, 15'h0001, 1'b0);
    join
    wait_idle();
    repeat (2) @(negedge clk);
    check_val("u0_frame_len_p4", last_len[0], NB * 4);
    check_val("u1_frame_len_p4", last_len[1], NB * 4);

    // back-to-back words with in_valid held high
    fork
      begin send(0, 15'h0001, 1'b1); send(0, 15'h0003, 1'b0); end
      begin send(1, 15'h7FFE, 1'b1); send(1, 15'h0003, 1'b0); end
    join
    wait_idle();

    // bit_en held high: one bit per clock
    be_mode = 1;
    fork
      begin send(0, W'($urandom), 1'b1); send(0, W'($urandom), 1'b0); end
      begin send(1, W'($urandom), 1'b1); send(1, W'($urandom), 1'b0); end
    join
    wait_idle();
    repeat (2) @(negedge clk);
    check_val("u0_frame_len_p1", last_len[0], NB);
    check_val("u1_frame_len_p1", last_len[1], NB);

    // random strobes and random word traffic
    be_mode = 2;
    fork
      rand_stream(0, 12);
      rand_stream(1, 12);
    join
    wait_idle();

    // reset in the middle of a frame, with 7 bits already completed
    be_mode = 0;
    send(0, W'($urandom), 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      if (rem[0] == NB + gapv(0) - 7) hit = 1'b1;
    end
    check_val("mid_frame_reached", {31'd0, hit}, 32'd1);
    @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    check_val("midrst_sout", {31'd0, sout[0]}, 32'd1);
    check_val("midrst_sframe", {31'd0, sframe[0]}, 32'd0);
    check_val("midrst_sfirst", {31'd0, sfirst[0]}, 32'd0);
    check_val("midrst_busy", {31'd0, busy[0]}, 32'd0);
    repeat (2) @(negedge clk);
    #2 nrst = 1'b1;
    @(negedge clk);
    check_val("post_rst_u0_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check_val("post_rst_u1_in_ready", {31'd0, in_ready[1]}, 32'd1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
